// File: rtl/catv_bus_pkg.sv
// Shared constants for the CATV bus fabric: master limits, ID width and the address map.
package catv_bus_pkg;

    localparam int MAX_N_MASTERS = 8;
    localparam int MASTER_ID_W   = 3;

    localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] RAM_END     = 32'h8000_0000;
    localparam logic [31:0] PERIPH_BASE = 32'h8000_0000;
    localparam logic [31:0] PERIPH_END  = 32'h9000_0000;

    typedef logic [MASTER_ID_W-1:0] master_id_t;

    // Round-robin successor of a master ID, wrapping at the number of masters present.
    function automatic master_id_t rr_next(input master_id_t id, input int n);
        if (int'(id) >= n - 1) begin
            return '0;
        end
        return id + master_id_t'(1);
    endfunction

endpackage

// File: rtl/catv_id_fifo.sv
// In-order FIFO of master IDs that tracks which master owns each outstanding read response.
module catv_id_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (int'(p) == DEPTH - 1) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    assign head   = mem_q[rd_ptr_q];
    assign do_pop = pop && !empty;

    // Storage, pointers and occupancy; the arbiter only pushes into a full FIFO when it also pops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push && do_pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/catv_bus_arbiter.sv
// Round-robin N:1 bus arbiter with grant locking under backpressure and in-order read response routing.
module catv_bus_arbiter
    import catv_bus_pkg::*;
#(
    parameter int N_MASTERS       = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [N_MASTERS-1:0]       m_valid_i,
    output logic [N_MASTERS-1:0]       m_ready_o,
    input  logic [N_MASTERS-1:0][31:0] m_addr_i,
    input  logic [N_MASTERS-1:0][31:0] m_wdata_i,
    input  logic [N_MASTERS-1:0]       m_we_i,
    input  logic [N_MASTERS-1:0][3:0]  m_strb_i,
    output logic [N_MASTERS-1:0]       m_rvalid_o,
    output logic [N_MASTERS-1:0][31:0] m_rdata_o,
    output logic                       s_valid_o,
    output logic                       s_we_o,
    output logic [31:0]                s_addr_o,
    output logic [31:0]                s_wdata_o,
    output logic [3:0]                 s_strb_o,
    input  logic                       s_ready_i,
    input  logic                       s_rvalid_i,
    input  logic [31:0]                s_rdata_i,
    output logic                       err_o
);

    master_id_t rr_q;
    master_id_t lock_id_q;
    logic       lock_q;
    logic       err_q;

    master_id_t grant;
    master_id_t id_hi;
    master_id_t id_lo;
    logic       hit_hi;
    logic       hit_lo;

    logic       sel_valid;
    logic       sel_we;
    logic       gate;
    logic       handshake;
    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    master_id_t head_id;

    // Grant selection: the locked master wins, otherwise the lowest valid ID at or above rr_q, else the lowest below it.
    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        id_hi  = '0;
        id_lo  = '0;
        for (int j = N_MASTERS - 1; j >= 0; j--) begin
            if (m_valid_i[j]) begin
                if (master_id_t'(j) >= rr_q) begin
                    hit_hi = 1'b1;
                    id_hi  = master_id_t'(j);
                end else begin
                    hit_lo = 1'b1;
                    id_lo  = master_id_t'(j);
                end
            end
        end
        if (lock_q) begin
            grant = lock_id_q;
        end else if (hit_hi) begin
            grant = id_hi;
        end else if (hit_lo) begin
            grant = id_lo;
        end else begin
            grant = rr_q;
        end
    end

    // Forward the granted request downstream; a read is held back while the ID FIFO is full and nothing drains it.
    always_comb begin
        sel_valid = 1'b0;
        sel_we    = 1'b0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        s_strb_o  = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant == master_id_t'(i) && m_valid_i[i]) begin
                sel_valid = 1'b1;
                sel_we    = m_we_i[i];
                s_addr_o  = m_addr_i[i];
                s_wdata_o = m_wdata_i[i];
                s_strb_o  = m_strb_i[i];
            end
        end
        s_we_o    = sel_we;
        pop       = rst_ni && s_rvalid_i && !fifo_empty;
        gate      = sel_valid && !sel_we && fifo_full && !pop;
        s_valid_o = rst_ni && sel_valid && !gate;
        handshake = s_valid_o && s_ready_i;
        push      = handshake && !sel_we;
        for (int i = 0; i < N_MASTERS; i++) begin
            m_ready_o[i] = s_valid_o && s_ready_i && (grant == master_id_t'(i));
        end
    end

    // Route a downstream read response to the master at the head of the ID FIFO, in the same cycle.
    always_comb begin
        for (int i = 0; i < N_MASTERS; i++) begin
            m_rvalid_o[i] = pop && (head_id == master_id_t'(i));
            m_rdata_o[i]  = (pop && (head_id == master_id_t'(i))) ? s_rdata_i : 32'h0;
        end
    end

    // Advance the round-robin pointer on a handshake and hold the grant while the slave stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q      <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else if (handshake) begin
            rr_q   <= rr_next(grant, N_MASTERS);
            lock_q <= 1'b0;
        end else if (s_valid_o) begin
            lock_q    <= 1'b1;
            lock_id_q <= grant;
        end
    end

    // A response arriving with nothing outstanding is dropped and flagged until the next reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (s_rvalid_i && fifo_empty) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

    catv_id_fifo #(
        .WIDTH(MASTER_ID_W),
        .DEPTH(MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push     (push),
        .push_data(grant),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (head_id)
    );

endmodule

// File: tb/tb_catv_bus_arbiter.sv
// Self-checking bench for catv_bus_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_catv_bus_arbiter;

    localparam int N     = 2;
    localparam int DEPTH = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        m_valid;
    logic [N-1:0]        m_ready;
    logic [N-1:0][31:0]  m_addr;
    logic [N-1:0][31:0]  m_wdata;
    logic [N-1:0]        m_we;
    logic [N-1:0][3:0]   m_strb;
    logic [N-1:0]        m_rvalid;
    logic [N-1:0][31:0]  m_rdata;
    logic                s_valid;
    logic                s_we;
    logic [31:0]         s_addr;
    logic [31:0]         s_wdata;
    logic [3:0]          s_strb;
    logic                s_ready;
    logic                s_rvalid;
    logic [31:0]         s_rdata;
    logic                err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    catv_bus_arbiter #(
        .N_MASTERS(N),
        .MAX_OUTSTANDING(DEPTH)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .m_valid_i (m_valid),
        .m_ready_o (m_ready),
        .m_addr_i  (m_addr),
        .m_wdata_i (m_wdata),
        .m_we_i    (m_we),
        .m_strb_i  (m_strb),
        .m_rvalid_o(m_rvalid),
        .m_rdata_o (m_rdata),
        .s_valid_o (s_valid),
        .s_we_o    (s_we),
        .s_addr_o  (s_addr),
        .s_wdata_o (s_wdata),
        .s_strb_o  (s_strb),
        .s_ready_i (s_ready),
        .s_rvalid_i(s_rvalid),
        .s_rdata_i (s_rdata),
        .err_o     (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_valid  = '0;
        m_we     = '0;
        m_addr   = '0;
        m_wdata  = '0;
        m_strb   = '0;
        s_ready  = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        m_valid  = 2'b11;
        s_ready  = 1'b1;
        s_rvalid = 1'b1;
        rst_n    = 1'b0;
        #4;
        n_cmp++; if (s_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_s_valid got %b want 0", s_valid); end
        n_cmp++; if (m_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_m_ready got %b want 00", m_ready); end
        n_cmp++; if (m_rvalid !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_m_rvalid got %b want 00", m_rvalid); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err got %b want 0", err); end
        tick();
        idle_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_contention();
        logic [1:0]  exp_ready;
        logic [31:0] exp_addr;
        do_reset();
        m_valid   = 2'b11;
        m_we      = 2'b11;
        m_addr[0] = 32'h100;
        m_addr[1] = 32'h200;
        s_ready   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            exp_ready = (c % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr  = (c % 2 == 0) ? 32'h100 : 32'h200;
            #4;
            n_cmp++; if (m_ready !== exp_ready) begin n_fail++; $display("[TB] FAIL contention_grant c%0d got %b want %b", c, m_ready, exp_ready); end
            n_cmp++; if (s_addr !== exp_addr) begin n_fail++; $display("[TB] FAIL contention_addr c%0d got %h want %h", c, s_addr, exp_addr); end
            tick();
        end
    endtask

    task automatic test_lock();
        do_reset();
        m_valid   = 2'b10;
        m_we      = 2'b11;
        m_addr[0] = 32'h0000_0040;
        m_addr[1] = 32'h0000_0300;
        s_ready   = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #4;
            n_cmp++; if (s_valid !== 1'b1 || s_addr !== 32'h300) begin n_fail++; $display("[TB] FAIL lock_hold c%0d got v=%b addr=%h want v=1 addr=300", c, s_valid, s_addr); end
            n_cmp++; if (m_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL lock_ready c%0d got %b want 00", c, m_ready); end
            tick();
            m_valid = 2'b11;
        end
        s_ready = 1'b1;
        #4;
        n_cmp++; if (m_ready !== 2'b10) begin n_fail++; $display("[TB] FAIL lock_handshake got %b want 10", m_ready); end
        tick();
        #4;
        n_cmp++; if (m_ready !== 2'b01 || s_addr !== 32'h40) begin n_fail++; $display("[TB] FAIL lock_next got ready=%b addr=%h want 01 addr=40", m_ready, s_addr); end
        tick();
    endtask

    task automatic test_routing();
        do_reset();
        s_ready   = 1'b1;
        m_valid   = 2'b01;
        m_addr[0] = 32'h180;
        #4;
        n_cmp++; if (m_ready !== 2'b01 || s_addr !== 32'h180 || s_we !== 1'b0) begin n_fail++; $display("[TB] FAIL route_req0 got ready=%b addr=%h we=%b", m_ready, s_addr, s_we); end
        tick();
        m_valid   = 2'b10;
        m_addr[1] = 32'h1000;
        #4;
        n_cmp++; if (m_ready !== 2'b10 || s_addr !== 32'h1000) begin n_fail++; $display("[TB] FAIL route_req1 got ready=%b addr=%h", m_ready, s_addr); end
        tick();
        m_valid  = 2'b00;
        s_rvalid = 1'b1;
        s_rdata  = 32'hAAAA_0001;
        #4;
        n_cmp++; if (m_rvalid !== 2'b01 || m_rdata[0] !== 32'hAAAA_0001 || m_rdata[1] !== 32'h0) begin n_fail++; $display("[TB] FAIL route_rsp0 got rv=%b d0=%h d1=%h", m_rvalid, m_rdata[0], m_rdata[1]); end
        tick();
        s_rdata = 32'hBBBB_0002;
        #4;
        n_cmp++; if (m_rvalid !== 2'b10 || m_rdata[1] !== 32'hBBBB_0002 || m_rdata[0] !== 32'h0) begin n_fail++; $display("[TB] FAIL route_rsp1 got rv=%b d0=%h d1=%h", m_rvalid, m_rdata[0], m_rdata[1]); end
        tick();
        s_rvalid = 1'b0;
        #4;
        n_cmp++; if (m_rvalid !== 2'b00 || err !== 1'b0) begin n_fail++; $display("[TB] FAIL route_quiet got rv=%b err=%b", m_rvalid, err); end
        tick();
    endtask

    task automatic test_full();
        do_reset();
        s_ready   = 1'b1;
        m_valid   = 2'b01;
        m_addr[0] = 32'h10;
        for (int c = 0; c < 2; c++) begin
            #4;
            n_cmp++; if (m_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL full_fill c%0d got %b want 01", c, m_ready); end
            tick();
        end
        m_valid   = 2'b10;
        m_addr[1] = 32'h20;
        #4;
        n_cmp++; if (s_valid !== 1'b0 || m_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL full_gate got v=%b ready=%b want 0 00", s_valid, m_ready); end
        tick();
        s_rvalid = 1'b1;
        s_rdata  = 32'h11;
        #4;
        n_cmp++; if (s_valid !== 1'b1 || m_ready !== 2'b10 || m_rvalid !== 2'b01) begin n_fail++; $display("[TB] FAIL full_pop_accept got v=%b ready=%b rv=%b", s_valid, m_ready, m_rvalid); end
        tick();
        m_valid = 2'b00;
        s_rdata = 32'h22;
        #4;
        n_cmp++; if (m_rvalid !== 2'b01 || m_rdata[0] !== 32'h22) begin n_fail++; $display("[TB] FAIL full_drain0 got rv=%b d0=%h", m_rvalid, m_rdata[0]); end
        tick();
        s_rdata = 32'h33;
        #4;
        n_cmp++; if (m_rvalid !== 2'b10 || m_rdata[1] !== 32'h33) begin n_fail++; $display("[TB] FAIL full_drain1 got rv=%b d1=%h", m_rvalid, m_rdata[1]); end
        tick();
        s_rvalid = 1'b0;
        #4;
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL full_err got %b want 0", err); end
        tick();
    endtask

    task automatic test_write();
        do_reset();
        s_ready    = 1'b1;
        m_valid    = 2'b10;
        m_we       = 2'b10;
        m_addr[1]  = 32'h8000_0000;
        m_wdata[1] = 32'h41;
        m_strb[1]  = 4'hF;
        #4;
        n_cmp++; if (s_valid !== 1'b1 || s_we !== 1'b1 || m_ready !== 2'b10) begin n_fail++; $display("[TB] FAIL write_hs got v=%b we=%b ready=%b", s_valid, s_we, m_ready); end
        n_cmp++; if (s_addr !== 32'h8000_0000 || s_wdata !== 32'h41 || s_strb !== 4'hF) begin n_fail++; $display("[TB] FAIL write_data got a=%h d=%h s=%h", s_addr, s_wdata, s_strb); end
        n_cmp++; if (m_rvalid !== 2'b00) begin n_fail++; $display("[TB] FAIL write_no_rsp got %b want 00", m_rvalid); end
        tick();
        m_valid = 2'b00;
        m_we    = 2'b00;
        #4;
        n_cmp++; if (s_valid !== 1'b0 || s_addr !== 32'h0 || s_wdata !== 32'h0 || m_rvalid !== 2'b00) begin n_fail++; $display("[TB] FAIL write_idle got v=%b a=%h d=%h rv=%b", s_valid, s_addr, s_wdata, m_rvalid); end
        tick();
        m_valid   = 2'b01;
        m_addr[0] = 32'h400;
        repeat (2) tick();
        #4;
        n_cmp++; if (s_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL write_count got v=%b want 0", s_valid); end
        tick();
        m_valid = 2'b11;
        m_we    = 2'b10;
        #4;
        n_cmp++; if (s_valid !== 1'b1 || s_we !== 1'b1 || m_ready !== 2'b10) begin n_fail++; $display("[TB] FAIL write_when_full got v=%b we=%b ready=%b", s_valid, s_we, m_ready); end
        tick();
    endtask

    task automatic test_reset_error();
        do_reset();
        s_ready   = 1'b1;
        m_valid   = 2'b01;
        m_addr[0] = 32'h80;
        repeat (2) tick();
        rst_n = 1'b0;
        #4;
        n_cmp++; if (s_valid !== 1'b0 || m_ready !== 2'b00 || err !== 1'b0) begin n_fail++; $display("[TB] FAIL rsterr_inreset got v=%b ready=%b err=%b", s_valid, m_ready, err); end
        tick();
        idle_inputs();
        rst_n = 1'b1;
        tick();
        s_rvalid = 1'b1;
        s_rdata  = 32'hDEAD_BEEF;
        #4;
        n_cmp++; if (m_rvalid !== 2'b00 || err !== 1'b0) begin n_fail++; $display("[TB] FAIL rsterr_drop got rv=%b err=%b want 00 0", m_rvalid, err); end
        tick();
        s_rvalid = 1'b0;
        #4;
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL rsterr_set got %b want 1", err); end
        repeat (3) tick();
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL rsterr_sticky got %b want 1", err); end
    endtask

    task automatic test_random();
        bit          pend [N];
        bit          p_we [N];
        logic [31:0] p_addr [N];
        logic [31:0] p_wdata [N];
        logic [3:0]  p_strb [N];
        int          q[$];
        int          rr;
        bit          lk;
        int          lk_id;
        int          g;
        bit          any;
        bit          popping;
        bit          e_sv;
        bit          e_hs;
        logic [N-1:0] e_ready;
        logic [N-1:0] e_rv;
        logic [31:0]  e_rd;
        do_reset();
        rr = 0;
        lk = 1'b0;
        lk_id = 0;
        for (int m = 0; m < N; m++) pend[m] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int m = 0; m < N; m++) begin
                if (!pend[m] && $urandom_range(0, 1) == 1) begin
                    pend[m]    = 1'b1;
                    p_we[m]    = ($urandom_range(0, 2) == 0);
                    p_addr[m]  = $urandom;
                    p_wdata[m] = $urandom;
                    p_strb[m]  = 4'($urandom_range(0, 15));
                end
                m_valid[m] = pend[m];
                m_we[m]    = pend[m] ? p_we[m] : 1'b0;
                m_addr[m]  = pend[m] ? p_addr[m] : 32'h0;
                m_wdata[m] = pend[m] ? p_wdata[m] : 32'h0;
                m_strb[m]  = pend[m] ? p_strb[m] : 4'h0;
            end
            s_ready  = ($urandom_range(0, 3) != 0);
            s_rvalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            s_rdata  = $urandom;
            any = 1'b0;
            g   = 0;
            if (lk) begin
                any = 1'b1;
                g   = lk_id;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (!any && pend[(rr + k) % N]) begin
                        any = 1'b1;
                        g   = (rr + k) % N;
                    end
                end
            end
            popping = s_rvalid && (q.size() > 0);
            e_sv    = any && pend[g] && !(!p_we[g] && q.size() >= DEPTH && !popping);
            e_hs    = e_sv && s_ready;
            e_ready = '0;
            if (e_hs) e_ready[g] = 1'b1;
            e_rv = '0;
            if (popping) e_rv[q[0]] = 1'b1;
            #4;
            n_cmp++; if (s_valid !== e_sv) begin n_fail++; $display("[TB] FAIL rand_s_valid cyc%0d got %b want %b", cyc, s_valid, e_sv); end
            n_cmp++; if (m_ready !== e_ready) begin n_fail++; $display("[TB] FAIL rand_m_ready cyc%0d got %b want %b", cyc, m_ready, e_ready); end
            n_cmp++; if (m_rvalid !== e_rv) begin n_fail++; $display("[TB] FAIL rand_m_rvalid cyc%0d got %b want %b", cyc, m_rvalid, e_rv); end
            for (int m = 0; m < N; m++) begin
                e_rd = e_rv[m] ? s_rdata : 32'h0;
                n_cmp++; if (m_rdata[m] !== e_rd) begin n_fail++; $display("[TB] FAIL rand_m_rdata cyc%0d m%0d got %h want %h", cyc, m, m_rdata[m], e_rd); end
            end
            if (e_sv) begin
                n_cmp++; if (s_addr !== p_addr[g] || s_we !== p_we[g] || s_wdata !== p_wdata[g] || s_strb !== p_strb[g]) begin n_fail++; $display("[TB] FAIL rand_fwd cyc%0d got a=%h we=%b d=%h s=%h want a=%h we=%b d=%h s=%h", cyc, s_addr, s_we, s_wdata, s_strb, p_addr[g], p_we[g], p_wdata[g], p_strb[g]); end
            end
            if (!any) begin
                n_cmp++; if (s_addr !== 32'h0 || s_wdata !== 32'h0) begin n_fail++; $display("[TB] FAIL rand_idle cyc%0d got a=%h d=%h want 0", cyc, s_addr, s_wdata); end
            end
            n_cmp++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL rand_err cyc%0d got %b want 0", cyc, err); end
            if (popping) void'(q.pop_front());
            if (e_hs) begin
                if (!p_we[g]) q.push_back(g);
                rr      = (g + 1) % N;
                lk      = 1'b0;
                pend[g] = 1'b0;
            end else if (e_sv) begin
                lk    = 1'b1;
                lk_id = g;
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_contention();
        test_lock();
        test_routing();
        test_full();
        test_write();
        test_reset_error();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/catv_bus_arbiter.md
CATV_BUS_ARBITER -- requirements
Module: catv_bus_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 2; number of requesting masters (2..8); master 0 is the instruction fetch port.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2; read responses in flight (1..4).
REQ-003 SHALL have port clk_i  in  1  the only clock.
REQ-004 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports m_valid_i / m_ready_o  in/out  [N_MASTERS]x1  per-master request handshake.
REQ-006 SHALL have ports m_addr_i, m_wdata_i  in  [N_MASTERS]x32  request address and write data.
REQ-007 SHALL have ports m_we_i  in  [N_MASTERS]x1 (write when 1) and m_strb_i  in  [N_MASTERS]x4 (byte strobes).
REQ-008 SHALL have ports m_rvalid_o / m_rdata_o  out  [N_MASTERS]x1 / x32  per-master read response.
REQ-009 SHALL have ports s_valid_o, s_we_o  out  1; s_addr_o, s_wdata_o  out  32; s_strb_o  out  4; s_ready_i  in  1; together the downstream request.
REQ-010 SHALL have ports s_rvalid_i  in  1 and s_rdata_i  in  32; in-order downstream read response, at least 1 cycle after acceptance.
REQ-011 SHALL have port err_o  out  1; sticky protocol error flag.

Function
REQ-012 SHALL select among asserted m_valid_i round-robin, starting search at pointer rr_q.
REQ-013 SHALL forward the granted master's addr/we/strb/wdata to s_*_o, set s_valid_o = m_valid_i[grant], and drive m_ready_o[grant] = s_ready_i; all other m_ready_o = 0.
REQ-014 SHALL count a handshake when s_valid_o && s_ready_i; on handshake rr_q <= (grant+1) mod N_MASTERS.
REQ-015 SHALL lock the grant (lock_q=1, lock_id_q=grant) while s_valid_o=1 and s_ready_i=0; next cycle grants lock_id_q regardless of other requesters; lock clears on handshake.
REQ-016 SHALL push the granted master ID into an in-order ID FIFO (depth MAX_OUTSTANDING) on every read handshake (m_we_i=0); writes push nothing and produce no response.
REQ-017 SHALL, on s_rvalid_i, pop the FIFO head and drive m_rvalid_o[head]=1, m_rdata_o[head]=s_rdata_i, same cycle (combinational); all other m_rvalid_o=0, m_rdata_o=0.
REQ-018 SHALL allow push and pop in the same cycle; count unchanged.
REQ-019 SHALL, when FIFO is full and no pop occurs this cycle, gate a granted read: s_valid_o=0, m_ready_o all 0; grant, lock and rr_q unchanged. A granted write proceeds regardless.
REQ-020 SHALL, when FIFO is full and s_rvalid_i=1, accept a new read in that cycle.
REQ-021 SHALL set err_o=1 on s_rvalid_i while FIFO empty (response dropped, no m_rvalid_o); err_o clears only on reset.
REQ-022 SHALL keep s_valid_o=0 and s_*_o data 0 when no master is valid.

Reset
REQ-023 SHALL, while rst_ni=0, clear rr_q=0, lock_q=0, FIFO count=0, err_o=0, and force s_valid_o=0, all m_ready_o=0, all m_rvalid_o=0.
REQ-024 SHALL discard in-flight responses on reset mid-operation; post-reset s_rvalid_i with empty FIFO sets err_o per REQ-021.

Structure
REQ-025 SHALL take MAX_N_MASTERS, the master-ID width and the address-map constants (RAM 0x0000_0000-0x8000_0000, periph 0x8000_0000-0x9000_0000) from shared package catv_bus_pkg.
REQ-026 SHALL implement the ID FIFO as sub-module catv_id_fifo (parameters WIDTH, DEPTH; push, pop, full, empty, head).

Verification
REQ-027 SHALL verify contention: m_valid=2'b11, s_ready=1 for 4 cycles, rr_q=0 -> grants 0,1,0,1.
REQ-028 SHALL verify lock: master 1 granted, s_ready=0 for 3 cycles; master 0 asserts meanwhile -> grant stays 1; handshake on cycle 4; master 0 served on cycle 5.
REQ-029 SHALL verify routing: reads by master 0 (addr 0x180) then master 1 (addr 0x1000); responses 0xAAAA_0001, 0xBBBB_0002 -> m_rvalid_o[0] with 0xAAAA_0001 first, then m_rvalid_o[1] with 0xBBBB_0002.
REQ-030 SHALL verify full: MAX_OUTSTANDING=2, two reads accepted, no response -> third read sees s_valid_o=0; s_rvalid_i=1 that cycle -> third read accepted same cycle.
REQ-031 SHALL verify writes: write to 0x8000_0000 strb 4'hF, data 0x41 -> handshake completes, no m_rvalid_o, FIFO count unchanged.
REQ-032 SHALL verify reset/error: rst_ni low with 2 reads outstanding, then high; s_rvalid_i=1 -> no m_rvalid_o, err_o=1 next cycle and held.
